// File: rtl/sample_trigger_sequencer.sv
// sample_trigger_sequencer
// Per-channel trigger sequencer for the sample discriminator.
// Each RX channel selects an analog and/or digital trigger source, waits a
// programmable delay, then holds a save-enable window open for a programmable
// holdoff (extended on retrigger). One timestamp is emitted per window, taken
// from the free-running sample counter at the trigger cycle.

module sample_trigger_sequencer #(
  parameter int unsigned CHANNELS        = 8,
  parameter int unsigned TX_CHANNELS     = 8,
  parameter int unsigned COUNT_WIDTH     = 32,
  parameter int unsigned TIMESTAMP_WIDTH = 48,
  localparam int unsigned ASRC_WIDTH     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned DSRC_WIDTH     = (TX_CHANNELS > 1) ? $clog2(TX_CHANNELS) : 1
) (
  input  logic                                adc_clk,
  input  logic                                adc_reset_n,
  input  logic                                adc_reset_state,
  input  logic [CHANNELS-1:0]                 adc_analog_event,
  input  logic [TX_CHANNELS-1:0]              adc_digital_trigger_in,
  input  logic [CHANNELS-1:0]                 adc_analog_trigger_enable,
  input  logic [CHANNELS-1:0]                 adc_digital_trigger_enable,
  input  logic [CHANNELS*ASRC_WIDTH-1:0]      adc_analog_trigger_source,
  input  logic [CHANNELS*DSRC_WIDTH-1:0]      adc_digital_trigger_source,
  input  logic [CHANNELS*COUNT_WIDTH-1:0]     adc_delay,
  input  logic [CHANNELS*COUNT_WIDTH-1:0]     adc_holdoff,
  output logic [CHANNELS-1:0]                 adc_save_enable,
  output logic [CHANNELS-1:0]                 adc_timestamp_valid,
  output logic [CHANNELS*TIMESTAMP_WIDTH-1:0] adc_timestamp,
  output logic [TIMESTAMP_WIDTH-1:0]          adc_sample_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } seq_state_t;

  logic [TIMESTAMP_WIDTH-1:0] sample_count;

  // Free-running sample counter shared by every channel; wraps naturally
  always_ff @(posedge adc_clk or negedge adc_reset_n) begin
    if (!adc_reset_n) begin
      sample_count <= '0;
    end else if (adc_reset_state) begin
      sample_count <= '0;
    end else begin
      sample_count <= sample_count + TIMESTAMP_WIDTH'(1);
    end
  end

  assign adc_sample_count = sample_count;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ASRC_WIDTH-1:0]      analog_src;
    logic [DSRC_WIDTH-1:0]      digital_src;
    logic [COUNT_WIDTH-1:0]     delay_cfg;
    logic [COUNT_WIDTH-1:0]     holdoff_cfg;
    logic                       trig;

    seq_state_t                 state;
    logic [COUNT_WIDTH-1:0]     count;
    logic [TIMESTAMP_WIDTH-1:0] ts_capture;
    logic                       save_en_q;
    logic                       ts_valid_q;
    logic [TIMESTAMP_WIDTH-1:0] ts_q;

    assign analog_src  = adc_analog_trigger_source[c*ASRC_WIDTH +: ASRC_WIDTH];
    assign digital_src = adc_digital_trigger_source[c*DSRC_WIDTH +: DSRC_WIDTH];
    assign delay_cfg   = adc_delay[c*COUNT_WIDTH +: COUNT_WIDTH];
    assign holdoff_cfg = adc_holdoff[c*COUNT_WIDTH +: COUNT_WIDTH];

    // Source selection: either enabled path can fire the channel
    assign trig = (adc_analog_trigger_enable[c]  & adc_analog_event[analog_src]) |
                  (adc_digital_trigger_enable[c] & adc_digital_trigger_in[digital_src]);

    // Channel sequencer: IDLE -> (DELAY) -> ACTIVE window with retrigger extension
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
      if (!adc_reset_n) begin
        state      <= ST_IDLE;
        count      <= '0;
        ts_capture <= '0;
        save_en_q  <= 1'b0;
        ts_valid_q <= 1'b0;
        ts_q       <= '0;
      end else if (adc_reset_state) begin
        state      <= ST_IDLE;
        count      <= '0;
        ts_capture <= '0;
        save_en_q  <= 1'b0;
        ts_valid_q <= 1'b0;
        ts_q       <= '0;
      end else begin
        ts_valid_q <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (trig) begin
              ts_capture <= sample_count;
              if (delay_cfg == '0) begin
                // Zero delay: open the window on the very next cycle
                state      <= ST_ACTIVE;
                count      <= holdoff_cfg;
                save_en_q  <= 1'b1;
                ts_valid_q <= 1'b1;
                ts_q       <= sample_count;
              end else begin
                state <= ST_DELAY;
                count <= delay_cfg;
              end
            end
          end
          ST_DELAY: begin
            // Triggers are deliberately ignored while the delay runs out
            if (count == COUNT_WIDTH'(1)) begin
              state      <= ST_ACTIVE;
              count      <= holdoff_cfg;
              save_en_q  <= 1'b1;
              ts_valid_q <= 1'b1;
              ts_q       <= ts_capture;
            end else begin
              count <= count - COUNT_WIDTH'(1);
            end
          end
          ST_ACTIVE: begin
            if (trig) begin
              // Retrigger extends the window without a new timestamp
              count <= holdoff_cfg;
            end else if (count == '0) begin
              state     <= ST_IDLE;
              save_en_q <= 1'b0;
            end else begin
              count <= count - COUNT_WIDTH'(1);
            end
          end
          default: begin
            state     <= ST_IDLE;
            count     <= '0;
            save_en_q <= 1'b0;
          end
        endcase
      end
    end

    assign adc_save_enable[c]                                  = save_en_q;
    assign adc_timestamp_valid[c]                              = ts_valid_q;
    assign adc_timestamp[c*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH] = ts_q;
  end

endmodule

// File: tb/tb_sample_trigger_sequencer.sv
// Bench for sample_trigger_sequencer: expected windows are queued as stimulus
// is driven and matched against windows observed on the outputs.

module tb_sample_trigger_sequencer;

  localparam int unsigned CH  = 8;
  localparam int unsigned TXC = 8;
  localparam int unsigned CW  = 32;
  localparam int unsigned TW  = 48;
  localparam int unsigned SW  = 3;

  logic              adc_clk;
  logic              adc_reset_n;
  logic              adc_reset_state;
  logic [CH-1:0]     adc_analog_event;
  logic [TXC-1:0]    adc_digital_trigger_in;
  logic [CH-1:0]     aen;
  logic [CH-1:0]     den;
  logic [CH*SW-1:0]  asrc;
  logic [CH*SW-1:0]  dsrc;
  logic [CH*CW-1:0]  dly;
  logic [CH*CW-1:0]  hold;
  logic [CH-1:0]     save_en;
  logic [CH-1:0]     ts_valid;
  logic [CH*TW-1:0]  ts;
  logic [TW-1:0]     scount;

  sample_trigger_sequencer #(
    .CHANNELS(CH), .TX_CHANNELS(TXC), .COUNT_WIDTH(CW), .TIMESTAMP_WIDTH(TW)
  ) dut (
    .adc_clk                   (adc_clk),
    .adc_reset_n               (adc_reset_n),
    .adc_reset_state           (adc_reset_state),
    .adc_analog_event          (adc_analog_event),
    .adc_digital_trigger_in    (adc_digital_trigger_in),
    .adc_analog_trigger_enable (aen),
    .adc_digital_trigger_enable(den),
    .adc_analog_trigger_source (asrc),
    .adc_digital_trigger_source(dsrc),
    .adc_delay                 (dly),
    .adc_holdoff               (hold),
    .adc_save_enable           (save_en),
    .adc_timestamp_valid       (ts_valid),
    .adc_timestamp             (ts),
    .adc_sample_count          (scount)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference sample counter
  logic [TW-1:0] mcnt;
  always @(posedge adc_clk or negedge adc_reset_n) begin
    if (!adc_reset_n)         mcnt <= '0;
    else if (adc_reset_state) mcnt <= '0;
    else                      mcnt <= mcnt + TW'(1);
  end

  typedef struct {
    int            ch;
    int            first;
    int            last;
    logic [TW-1:0] ts;
  } win_t;

  win_t exp_q[$];

  task automatic expect_win(input int ch, input int first, input int last, input int t);
    win_t w;
    w.ch = ch; w.first = first; w.last = last; w.ts = TW'(t);
    exp_q.push_back(w);
  endtask

  logic          mon_en;
  logic          in_win      [CH];
  int            w_first     [CH];
  int            w_tsv       [CH];
  logic          w_first_tsv [CH];
  logic [TW-1:0] w_ts        [CH];

  task automatic close_window(input int c, input int last, input logic [TW-1:0] ts_now);
    int idx;
    win_t e;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].ch == c) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      check_val($sformatf("unexpected_win_ch%0d_first%0d", c, w_first[c]), 64'(1), 64'(0));
    end else begin
      e = exp_q[idx];
      exp_q.delete(idx);
      check_val($sformatf("win_first_ch%0d", c), 64'(w_first[c]), 64'(e.first));
      check_val($sformatf("win_last_ch%0d", c), 64'(last), 64'(e.last));
      check_val($sformatf("win_ts_ch%0d", c), 64'(w_ts[c]), 64'(e.ts));
      check_val($sformatf("ts_hold_ch%0d", c), 64'(ts_now), 64'(e.ts));
      check_val($sformatf("tsv_first_ch%0d", c), 64'(w_first_tsv[c]), 64'(1));
      check_val($sformatf("tsv_count_ch%0d", c), 64'(w_tsv[c]), 64'(1));
    end
  endtask

  // Output monitor: reconstruct windows and match them against the queue
  always @(negedge adc_clk) begin
    check_val("sample_count", 64'(scount), 64'(mcnt));
    for (int c = 0; c < CH; c++) begin
      if (!mon_en || !adc_reset_n) begin
        in_win[c] = 1'b0;
      end else begin
        if (ts_valid[c] && !save_en[c])
          check_val($sformatf("tsv_outside_win_ch%0d", c), 64'(1), 64'(0));
        if (save_en[c] && !in_win[c]) begin
          in_win[c]      = 1'b1;
          w_first[c]     = int'(mcnt);
          w_tsv[c]       = 0;
          w_first_tsv[c] = ts_valid[c];
          w_ts[c]        = ts[c*TW +: TW];
        end
        if (save_en[c] && ts_valid[c]) w_tsv[c]++;
        if (!save_en[c] && in_win[c]) begin
          in_win[c] = 1'b0;
          close_window(c, int'(mcnt) - 1, ts[c*TW +: TW]);
        end
      end
    end
  end

  task automatic clear_cfg();
    aen = '0; den = '0; asrc = '0; dsrc = '0; dly = '0; hold = '0;
  endtask

  task automatic cfg(input int ch, input logic ae, input logic de, input int a_s,
                     input int d_s, input int d, input int h);
    aen[ch]              = ae;
    den[ch]              = de;
    asrc[ch*SW +: SW]    = SW'(a_s);
    dsrc[ch*SW +: SW]    = SW'(d_s);
    dly[ch*CW +: CW]     = CW'(d);
    hold[ch*CW +: CW]    = CW'(h);
  endtask

  task automatic at_count(input int n);
    int guard;
    guard = 0;
    while (mcnt != TW'(n) && guard < 3000) begin
      @(negedge adc_clk);
      guard++;
    end
    if (guard >= 3000) check_val($sformatf("timeout_at_count_%0d", n), 64'(mcnt), 64'(n));
  endtask

  task automatic pulse_a(input int idx);
    adc_analog_event[idx] = 1'b1;
    @(negedge adc_clk);
    adc_analog_event[idx] = 1'b0;
  endtask

  task automatic pulse_d(input int idx);
    adc_digital_trigger_in[idx] = 1'b1;
    @(negedge adc_clk);
    adc_digital_trigger_in[idx] = 1'b0;
  endtask

  initial begin
    adc_reset_n            = 1'b0;
    adc_reset_state        = 1'b0;
    adc_analog_event       = '0;
    adc_digital_trigger_in = '0;
    mon_en                 = 1'b0;
    clear_cfg();

    repeat (3) @(negedge adc_clk);
    check_val("rst_save_en", 64'(save_en), 64'(0));
    check_val("rst_ts_valid", 64'(ts_valid), 64'(0));
    check_val("rst_ts_any", 64'(|ts), 64'(0));
    check_val("rst_scount", 64'(scount), 64'(0));
    #2 adc_reset_n = 1'b1;
    mon_en = 1'b1;

    // Retrigger: D=0 H=4, events at 10 and 13
    cfg(0, 1'b1, 1'b0, 0, 0, 0, 4);
    expect_win(0, 11, 18, 10);
    at_count(10); pulse_a(0);
    at_count(13); pulse_a(0);

    // Basic window: D=0 H=3, event at 100
    at_count(50);
    cfg(0, 1'b1, 1'b0, 0, 0, 0, 3);
    expect_win(0, 101, 104, 100);
    at_count(100); pulse_a(0);

    // Delay: D=5 H=0 digital src 2 at 200, ignored trigger at 203
    at_count(150);
    clear_cfg();
    cfg(0, 1'b0, 1'b1, 0, 2, 5, 0);
    expect_win(0, 206, 206, 200);
    at_count(200); pulse_d(2);
    at_count(203); pulse_d(2);

    // Source routing: ch3 analog 5 / digital 7 disabled; ch5 listens elsewhere
    at_count(250);
    clear_cfg();
    cfg(3, 1'b1, 1'b0, 5, 7, 2, 2);
    cfg(5, 1'b1, 1'b1, 0, 3, 0, 0);
    expect_win(3, 313, 315, 310);
    at_count(300); pulse_d(7);
    at_count(310); pulse_a(5);

    // Back-to-back windows with the minimum one-cycle gap
    at_count(350);
    clear_cfg();
    cfg(0, 1'b1, 1'b0, 0, 0, 0, 1);
    expect_win(0, 401, 402, 400);
    expect_win(0, 404, 405, 403);
    at_count(400); pulse_a(0);
    at_count(403); pulse_a(0);

    // Shared source, independent holdoffs; mid-window holdoff change has no effect
    at_count(450);
    clear_cfg();
    cfg(1, 1'b1, 1'b0, 4, 0, 1, 2);
    cfg(2, 1'b1, 1'b0, 4, 0, 1, 5);
    expect_win(1, 502, 504, 500);
    expect_win(2, 502, 507, 500);
    at_count(500); pulse_a(4);
    at_count(503); hold[2*CW +: CW] = CW'(9);

    // Synchronous state clear during DELAY coinciding with a new trigger
    at_count(550);
    clear_cfg();
    cfg(0, 1'b1, 1'b0, 0, 0, 10, 2);
    cfg(1, 1'b1, 1'b0, 1, 0, 0, 1);
    at_count(600); pulse_a(0);
    at_count(603);
    adc_reset_state  = 1'b1;
    adc_analog_event = CH'(3);
    @(negedge adc_clk);
    adc_reset_state  = 1'b0;
    adc_analog_event = '0;
    check_val("rst_state_scount", 64'(scount), 64'(0));
    check_val("rst_state_save_en", 64'(save_en), 64'(0));
    repeat (20) @(negedge adc_clk);
    check_val("rst_state_quiet", 64'(save_en), 64'(0));
    check_val("rst_state_scount20", 64'(scount), 64'(20));

    // Asynchronous reset in the middle of a window
    clear_cfg();
    mon_en = 1'b0;
    cfg(0, 1'b1, 1'b0, 0, 0, 0, 50);
    at_count(30); pulse_a(0);
    at_count(40);
    check_val("pre_rst_save_en", 64'(save_en[0]), 64'(1));
    #2 adc_reset_n = 1'b0;
    #1;
    check_val("async_save_en", 64'(save_en), 64'(0));
    check_val("async_ts_valid", 64'(ts_valid), 64'(0));
    check_val("async_ts_any", 64'(|ts), 64'(0));
    check_val("async_scount", 64'(scount), 64'(0));
    clear_cfg();
    repeat (2) @(negedge adc_clk);
    #2 adc_reset_n = 1'b1;
    #1;
    check_val("release_scount0", 64'(scount), 64'(0));
    @(negedge adc_clk);
    check_val("release_scount1", 64'(scount), 64'(1));
    @(negedge adc_clk);
    check_val("release_scount2", 64'(scount), 64'(2));
    mon_en = 1'b1;

    repeat (5) @(negedge adc_clk);
    check_val("leftover_windows", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_trigger_sequencer.md
Name: sample_trigger_sequencer

Overview:
- Per-channel trigger sequencer that sits between the sample discriminator's threshold comparators / digital trigger inputs and its save datapath.
- For each RX channel it selects a trigger source, applies a programmable delay, then holds a save-enable window open for a programmable holdoff, extending the window on retrigger.
- Emits one timestamp per window, taken from a free-running sample counter.
- The discriminator uses save-enable to gate adc_data_out and timestamp-valid to drive adc_timestamps_out.

Parameters:
CHANNELS, 8, number of RX channels (rx_pkg::CHANNELS)
TX_CHANNELS, 8, number of digital trigger inputs (tx_pkg::CHANNELS)
COUNT_WIDTH, 32, width of delay/holdoff counters
TIMESTAMP_WIDTH, 48, width of free-running sample counter and timestamps

Ports:
adc_clk  in  1  sole clock
adc_reset_n  in  1  asynchronous, active-low reset
adc_reset_state  in  1  synchronous clear of all sequencer state; active high
adc_analog_event  in  CHANNELS  per-channel threshold-exceeded flag from the comparators
adc_digital_trigger_in  in  TX_CHANNELS  digital triggers from the TX side
adc_analog_trigger_enable  in  CHANNELS  per-channel analog trigger enable
adc_digital_trigger_enable  in  CHANNELS  per-channel digital trigger enable
adc_analog_trigger_source  in  CHANNELS x clog2(CHANNELS)  analog event index per channel
adc_digital_trigger_source  in  CHANNELS x clog2(TX_CHANNELS)  digital trigger index per channel
adc_delay  in  CHANNELS x COUNT_WIDTH  cycles from trigger to window open
adc_holdoff  in  CHANNELS x COUNT_WIDTH  extra cycles the window stays open
adc_save_enable  out  CHANNELS  window open; gates sample saving
adc_timestamp_valid  out  CHANNELS  one-cycle pulse on the first cycle of each window
adc_timestamp  out  CHANNELS x TIMESTAMP_WIDTH  sample count captured at the trigger cycle
adc_sample_count  out  TIMESTAMP_WIDTH  free-running sample counter

Behaviour:
- Reset (adc_reset_n=0, asynchronous):
  - all channels go to IDLE; counters cleared.
  - adc_save_enable=0, adc_timestamp_valid=0, adc_timestamp=0, adc_sample_count=0.
- adc_reset_state=1 (synchronous, highest priority): same effect as reset on the next edge; all triggers that cycle are ignored.
- adc_sample_count: increments by 1 every cycle and wraps modulo 2^TIMESTAMP_WIDTH.
- Per-channel trigger (combinational): trig[c] = (analog_en[c] & adc_analog_event[analog_src[c]]) | (digital_en[c] & adc_digital_trigger_in[digital_src[c]]).
  - Both enables are 0 -> channel never triggers.
- State machine per channel: IDLE, DELAY, ACTIVE. Outputs are registered.
  - IDLE:
    - on trig at cycle t: capture ts = adc_sample_count(t).
    - if adc_delay[c]==0: go to ACTIVE, counter=adc_holdoff[c].
    - else: go to DELAY, counter=adc_delay[c].
  - DELAY:
    - counter decrements each cycle.
    - when counter==1: go to ACTIVE, counter=adc_holdoff[c] (value at that cycle).
    - triggers are ignored in DELAY.
  - ACTIVE:
    - adc_save_enable[c]=1.
    - trig reloads counter=adc_holdoff[c].
    - else if counter==0: go to IDLE.
    - else: counter decrements.
- Latency:
  - delay D, trigger at t -> save_enable first high at t+1+D.
  - holdoff H, no retrigger -> window is exactly H+1 cycles.
  - retrigger at active cycle r -> last high cycle is r+1+H.
- Timestamp: adc_timestamp_valid[c] pulses for one cycle, coincident with the first save_enable cycle of the window.
  - adc_timestamp[c] holds the captured ts from that cycle until the next window.
  - a retrigger does not produce a new timestamp.
- Back-to-back windows: a trigger on the cycle right after returning to IDLE starts a new window normally; the minimum gap is 1 cycle with save_enable=0.
- Configuration inputs are sampled live; there is no shadowing.
  - delay is latched at trigger; holdoff is latched at each load or reload.
  - changing a value mid-window affects only the next load.
- Counter and timestamp widths are fixed; no saturation logic. COUNT_WIDTH max delay is 2^32-1.
- Channels are fully independent. The same source may feed several channels.

Test Plan:
- Reset: hold adc_reset_n=0 mid-window -> all outputs 0 immediately (asynchronously). On release, adc_sample_count counts 0,1,2…
- Basic window: ch0, analog src 0, D=0, H=3, event pulse at count 100 -> save_enable high counts 101–104; ts_valid at 101; ts=100.
- Delay: D=5, H=0, digital src 2 pulse at count 200 -> save_enable high only at 206; ts=200; an event at 203 is ignored.
- Retrigger: D=0, H=4, events at 10 and 13 -> save_enable high 11–18, a single ts_valid at 11 with ts=10.
- Source routing: ch3 analog src=5, digital src=7, digital_en=0 -> adc_digital_trigger_in[7] causes no window; adc_analog_event[5] opens ch3 only; other channels stay 0.
- adc_reset_state asserted during DELAY at the same cycle as a new trigger -> all channels IDLE, no window, adc_sample_count=0 next cycle.
